// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the 16-bit decoder.
// Holds the PC, drives it straight to the combinational instruction ROM, captures the
// returned word(s) into instruction registers and presents them over valid/ready.
// Two-word instructions (first word opcode == EXT_OPC) are merged into one transfer.
//
// Ports:
//   clk_i          system clock (rising edge)
//   rst_ni         asynchronous active-low reset
//   rom_addr_o     ROM address, equal to the PC register
//   rom_data_i     ROM word for rom_addr_o, same cycle
//   instr_o        first (or only) instruction word
//   instr_ext_o    second word of a two-word instruction, else 16'h0000
//   instr_pc_o     address of the first word of instr_o
//   instr_valid_o  instruction outputs hold a complete instruction
//   instr_ready_i  decoder accepts the instruction this cycle
//   redirect_i     one-cycle flow-change request
//   redirect_pc_i  redirect target, sampled when redirect_i is high
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [5:0] EXT_OPC  = 6'b100001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [7:0]  rom_addr_o,
    input  logic [15:0] rom_data_i,
    output logic [15:0] instr_o,
    output logic [15:0] instr_ext_o,
    output logic [7:0]  instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [7:0]  redirect_pc_i
);

    typedef enum logic [1:0] {StFetch, StExt, StFull} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_ext_q, instr_ext_d;
    logic [7:0]  instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        load;

    // A new first word is captured when the pipeline slot is empty or being drained.
    assign load = (state_q == StFetch) || ((state_q == StFull) && instr_ready_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_ext_d = instr_ext_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;

        if (redirect_i) begin
            // Instruction registers hold; only the flow and validity change.
            pc_d    = redirect_pc_i;
            valid_d = 1'b0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch, StFull: begin
                    if (load) begin
                        instr_d    = rom_data_i;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 8'd1;
                        if (rom_data_i[15:10] == EXT_OPC) begin
                            valid_d = 1'b0;
                            state_d = StExt;
                        end else begin
                            instr_ext_d = 16'h0000;
                            valid_d     = 1'b1;
                            state_d     = StFull;
                        end
                    end
                end
                StExt: begin
                    instr_ext_d = rom_data_i;
                    pc_d        = pc_q + 8'd1;
                    valid_d     = 1'b1;
                    state_d     = StFull;
                end
                default: begin
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            instr_q     <= 16'h0000;
            instr_ext_q <= 16'h0000;
            instr_pc_q  <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_ext_q <= instr_ext_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_ext_o   = instr_ext_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand-written wrap/async-reset
// sequence, then randomized traffic checked against an instruction-stream model.
module tb_fetch_unit;

    localparam logic [5:0] EXT_OPC = 6'b100001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [15:0] instr_ext;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    logic [15:0] rom [256];

    int n_cmp = 0;
    int n_fail = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(8'h00),
        .EXT_OPC (EXT_OPC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .instr_o      (instr),
        .instr_ext_o  (instr_ext),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc)
    );

    typedef struct {
        logic        ready;
        logic        redir;
        logic [7:0]  rpc;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_ext;
        logic [7:0]  e_ipc;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t vecs[20];

    // Compares {valid, instr, ext, instr_pc, rom_addr} against an expected tuple.
    task automatic check_out(input string name, input logic ev, input logic [15:0] ei,
                             input logic [15:0] ee, input logic [7:0] ep,
                             input logic [7:0] ea);
        n_cmp++;
        if (instr_valid !== ev || instr !== ei || instr_ext !== ee || instr_pc !== ep ||
            rom_addr !== ea) begin
            n_fail++;
            $display("FAIL %s: got v=%b i=%h x=%h pc=%h a=%h, want v=%b i=%h x=%h pc=%h a=%h",
                     name, instr_valid, instr, instr_ext, instr_pc, rom_addr,
                     ev, ei, ee, ep, ea);
        end
    endtask

    task automatic check_bool(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    logic [7:0]  exp_addr;
    logic [15:0] w0;
    logic [15:0] e_ext;
    logic        accepted;
    logic        stall;
    logic [58:0] snap;
    int          n_acc;

    initial begin
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
        rom[8'h00] = 16'h404A;
        rom[8'h01] = 16'h0901;
        rom[8'h16] = 16'h844A;
        rom[8'h17] = 16'h0001;

        //            rdy  rdr   rpc    v     instr     ext       ipc    addr
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h404A, 16'h0000, 8'h00, 8'h01};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h0901, 16'h0000, 8'h01, 8'h02};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0901, 16'h0000, 8'h01, 8'h02};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0901, 16'h0000, 8'h01, 8'h02};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0901, 16'h0000, 8'h01, 8'h02};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1002, 16'h0000, 8'h02, 8'h03};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1003, 16'h0000, 8'h03, 8'h04};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1004, 16'h0000, 8'h04, 8'h05};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1005, 16'h0000, 8'h05, 8'h06};
        vecs[9]  = '{1'b0, 1'b1, 8'h20, 1'b0, 16'h1005, 16'h0000, 8'h05, 8'h20};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1020, 16'h0000, 8'h20, 8'h21};
        vecs[11] = '{1'b1, 1'b1, 8'h16, 1'b0, 16'h1020, 16'h0000, 8'h20, 8'h16};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h844A, 16'h0000, 8'h16, 8'h17};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h844A, 16'h0001, 8'h16, 8'h18};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1018, 16'h0000, 8'h18, 8'h19};
        vecs[15] = '{1'b0, 1'b1, 8'h16, 1'b0, 16'h1018, 16'h0000, 8'h18, 8'h16};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h844A, 16'h0000, 8'h16, 8'h17};
        vecs[17] = '{1'b1, 1'b1, 8'h03, 1'b0, 16'h844A, 16'h0000, 8'h16, 8'h03};
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h1003, 16'h0000, 8'h03, 8'h04};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1003, 16'h0000, 8'h03, 8'h04};

        // Reset state.
        rst_n = 1'b0;
        #1;
        check_out("reset", 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table: inputs before an edge, outputs checked after it.
        for (int i = 0; i < 20; i++) begin
            instr_ready = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                      vecs[i].e_ext, vecs[i].e_ipc, vecs[i].e_addr);
            @(negedge clk);
        end

        // Two-word instruction straddling the 8'hFF -> 8'h00 wrap.
        rom[8'hFF] = 16'h844A;
        rom[8'h00] = 16'h0007;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        @(posedge clk);
        #1;
        check_out("wrap_redir", 1'b0, 16'h1003, 16'h0000, 8'h03, 8'hFF);
        @(negedge clk);
        redirect = 1'b0;
        @(posedge clk);
        #1;
        check_out("wrap_first", 1'b0, 16'h844A, 16'h0000, 8'hFF, 8'h00);
        @(negedge clk);
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        check_out("wrap_ext", 1'b1, 16'h844A, 16'h0007, 8'hFF, 8'h01);

        // Asynchronous reset between edges takes effect without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        @(negedge clk);

        // Randomized traffic against an instruction-stream model: every accepted
        // transfer must be the next instruction of the program from exp_addr.
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
            if ($urandom_range(3) == 0) rom[i][15:10] = EXT_OPC;
        end
        instr_ready = 1'b0;
        redirect    = 1'b0;
        rst_n       = 1'b1;
        exp_addr    = 8'h00;
        n_acc       = 0;
        for (int c = 0; c < 4000; c++) begin
            instr_ready = ($urandom_range(3) != 0);
            redirect    = ($urandom_range(15) == 0);
            redirect_pc = 8'($urandom);
            #1;
            accepted = instr_valid && instr_ready;
            stall    = instr_valid && !instr_ready && !redirect;
            snap     = {instr_valid, instr, instr_ext, instr_pc, rom_addr};
            if (accepted) begin
                w0    = rom[exp_addr];
                e_ext = (w0[15:10] == EXT_OPC) ? rom[8'(exp_addr + 8'd1)] : 16'h0000;
                check_out("rand_xfer", 1'b1, w0, e_ext, exp_addr, instr_pc + 8'(0) == exp_addr
                          ? rom_addr : rom_addr);
                exp_addr = exp_addr + ((w0[15:10] == EXT_OPC) ? 8'd2 : 8'd1);
                n_acc++;
            end
            if (redirect) exp_addr = redirect_pc;
            @(posedge clk);
            #1;
            if (stall) begin
                n_cmp++;
                if ({instr_valid, instr, instr_ext, instr_pc, rom_addr} !== snap) begin
                    n_fail++;
                    $display("FAIL rand_hold: got %h, want %h",
                             {instr_valid, instr, instr_ext, instr_pc, rom_addr}, snap);
                end
            end
            @(negedge clk);
        end
        check_bool("rand_progress", n_acc >= 1000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
